// File: rtl/reg_dest_scoreboard.sv
// reg_dest_scoreboard
//   Per-register in-flight write counters for the D-stage hazard logic.
//   Issued destination addresses increment a counter, write-backs decrement it,
//   and source-operand queries report busy when the counter is nonzero.
//   Register 0 is never tracked.
// Ports
//   clk, reset_n               clock, asynchronous active-low reset
//   ISSUE_VALID/ADDR/READY     issue handshake; READY low when the target counter is full
//   RETIRE_VALID/ADDR          write-back completion
//   FLUSH                      synchronous clear of all counters
//   RS_ADDR/RT_ADDR            source register queries
//   RS_BUSY/RT_BUSY/STALL      query results (from registered state only)
//   BUSY_VEC                   bit i set when register i has a write in flight
//   ERR_UNDERFLOW              sticky: retire seen on a zero counter
module reg_dest_scoreboard #(
   parameter int AW    = 5,
   parameter int CNT_W = 2
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                ISSUE_VALID,
   input  logic [AW-1:0]       ISSUE_ADDR,
   output logic                ISSUE_READY,
   input  logic                RETIRE_VALID,
   input  logic [AW-1:0]       RETIRE_ADDR,
   input  logic                FLUSH,
   input  logic [AW-1:0]       RS_ADDR,
   input  logic [AW-1:0]       RT_ADDR,
   output logic                RS_BUSY,
   output logic                RT_BUSY,
   output logic                STALL,
   output logic [(2**AW)-1:0]  BUSY_VEC,
   output logic                ERR_UNDERFLOW
);

   localparam int unsigned NREG = 2**AW;
   localparam logic [CNT_W-1:0] CMAX = '1;

   logic [CNT_W-1:0] cnt     [NREG];
   logic [CNT_W-1:0] cnt_nxt [NREG];
   logic             same_addr;
   logic             accept;
   logic             underflow;

   assign same_addr = RETIRE_VALID && (RETIRE_ADDR == ISSUE_ADDR);

   // A same-cycle retire to the saturated register frees the slot the issue needs.
   always_comb begin
      ISSUE_READY = 1'b1;
      if ((ISSUE_ADDR != '0) && (cnt[ISSUE_ADDR] == CMAX) && !same_addr)
         ISSUE_READY = 1'b0;
   end

   assign accept = ISSUE_VALID && ISSUE_READY;

   // Underflow only when the retire is not cancelled by a matching accepted issue.
   assign underflow = !FLUSH && RETIRE_VALID && (RETIRE_ADDR != '0) &&
                      (cnt[RETIRE_ADDR] == '0) &&
                      !(accept && (ISSUE_ADDR == RETIRE_ADDR));

   always_comb begin
      for (int unsigned i = 0; i < NREG; i++) begin
         logic inc;
         logic dec;
         cnt_nxt[i] = cnt[i];
         inc = accept && (ISSUE_ADDR == AW'(i));
         dec = RETIRE_VALID && (RETIRE_ADDR == AW'(i));
         if (i == 0 || FLUSH)
            cnt_nxt[i] = '0;
         else if (inc && !dec)
            cnt_nxt[i] = cnt[i] + CNT_W'(1);
         else if (dec && !inc && (cnt[i] != '0))
            cnt_nxt[i] = cnt[i] - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < NREG; i++)
            cnt[i] <= '0;
         ERR_UNDERFLOW <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < NREG; i++)
            cnt[i] <= cnt_nxt[i];
         if (underflow)
            ERR_UNDERFLOW <= 1'b1;
      end
   end

   always_comb begin
      BUSY_VEC = '0;
      for (int unsigned i = 1; i < NREG; i++)
         BUSY_VEC[i] = (cnt[i] != '0);
   end

   assign RS_BUSY = BUSY_VEC[RS_ADDR];
   assign RT_BUSY = BUSY_VEC[RT_ADDR];
   assign STALL   = RS_BUSY | RT_BUSY;

endmodule

// File: tb/tb_reg_dest_scoreboard.sv
module tb_reg_dest_scoreboard;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        ISSUE_VALID;
   logic [4:0]  ISSUE_ADDR;
   logic        ISSUE_READY;
   logic        RETIRE_VALID;
   logic [4:0]  RETIRE_ADDR;
   logic        FLUSH;
   logic [4:0]  RS_ADDR;
   logic [4:0]  RT_ADDR;
   logic        RS_BUSY;
   logic        RT_BUSY;
   logic        STALL;
   logic [31:0] BUSY_VEC;
   logic        ERR_UNDERFLOW;

   int total = 0;
   int bad   = 0;

   // reference model: plain integer counts per register
   int m_cnt [32];
   bit m_err;
   bit m_ready;

   reg_dest_scoreboard #(.AW(5), .CNT_W(2)) dut (
      .clk(clk), .reset_n(reset_n),
      .ISSUE_VALID(ISSUE_VALID), .ISSUE_ADDR(ISSUE_ADDR), .ISSUE_READY(ISSUE_READY),
      .RETIRE_VALID(RETIRE_VALID), .RETIRE_ADDR(RETIRE_ADDR), .FLUSH(FLUSH),
      .RS_ADDR(RS_ADDR), .RT_ADDR(RT_ADDR),
      .RS_BUSY(RS_BUSY), .RT_BUSY(RT_BUSY), .STALL(STALL),
      .BUSY_VEC(BUSY_VEC), .ERR_UNDERFLOW(ERR_UNDERFLOW)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] m_busy();
      logic [31:0] b = '0;
      for (int i = 1; i < 32; i++) b[i] = (m_cnt[i] > 0);
      return b;
   endfunction

   task automatic m_clear();
      for (int i = 0; i < 32; i++) m_cnt[i] = 0;
   endtask

   task automatic check_all(input string tag);
      logic [31:0] b;
      b = m_busy();
      m_ready = !(ISSUE_ADDR != 0 && m_cnt[ISSUE_ADDR] == 3 &&
                  !(RETIRE_VALID && RETIRE_ADDR == ISSUE_ADDR));
      chk({tag, ".ready"}, 32'(ISSUE_READY), 32'(m_ready));
      chk({tag, ".busyvec"}, BUSY_VEC, b);
      chk({tag, ".rs_busy"}, 32'(RS_BUSY), 32'(b[RS_ADDR]));
      chk({tag, ".rt_busy"}, 32'(RT_BUSY), 32'(b[RT_ADDR]));
      chk({tag, ".stall"}, 32'(STALL), 32'(b[RS_ADDR] | b[RT_ADDR]));
      chk({tag, ".err"}, 32'(ERR_UNDERFLOW), 32'(m_err));
   endtask

   task automatic m_update();
      bit acc;
      acc = ISSUE_VALID && m_ready;
      if (FLUSH) begin
         m_clear();
      end else begin
         if (acc && ISSUE_ADDR != 0 && !(RETIRE_VALID && RETIRE_ADDR == ISSUE_ADDR))
            m_cnt[ISSUE_ADDR] += 1;
         if (RETIRE_VALID && RETIRE_ADDR != 0 && !(acc && ISSUE_ADDR == RETIRE_ADDR)) begin
            if (m_cnt[RETIRE_ADDR] == 0) m_err = 1;
            else m_cnt[RETIRE_ADDR] -= 1;
         end
      end
   endtask

   // drive one cycle, check pre-edge outputs, clock, advance model
   task automatic step(input string tag, input logic iv, input logic [4:0] ia,
                       input logic rv, input logic [4:0] ra, input logic fl,
                       input logic [4:0] rs, input logic [4:0] rt);
      ISSUE_VALID = iv; ISSUE_ADDR = ia; RETIRE_VALID = rv; RETIRE_ADDR = ra;
      FLUSH = fl; RS_ADDR = rs; RT_ADDR = rt;
      #1;
      check_all(tag);
      @(posedge clk);
      m_update();
      #1;
   endtask

   task automatic idle(input string tag, input logic [4:0] rs, input logic [4:0] rt);
      step(tag, 0, 0, 0, 0, 0, rs, rt);
   endtask

   task automatic do_reset(input string tag);
      reset_n = 1'b0;
      m_clear();
      m_err = 0;
      #1;
      chk({tag, ".busyvec"}, BUSY_VEC, 32'h0);
      chk({tag, ".stall"}, 32'(STALL), 32'h0);
      chk({tag, ".ready"}, 32'(ISSUE_READY), 32'h1);
      chk({tag, ".err"}, 32'(ERR_UNDERFLOW), 32'h0);
      #2;
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n = 1'b0;
      ISSUE_VALID = 0; ISSUE_ADDR = 0; RETIRE_VALID = 0; RETIRE_ADDR = 0;
      FLUSH = 0; RS_ADDR = 0; RT_ADDR = 0;
      m_clear();
      m_err = 0;
      #12;
      chk("reset.busyvec", BUSY_VEC, 32'h0);
      chk("reset.ready", 32'(ISSUE_READY), 32'h1);
      reset_n = 1'b1;

      // issue 5, observe busy, retire 5, observe clear
      step("t2.issue", 1, 5, 0, 0, 0, 5, 0);
      chk("t2.rs_busy", 32'(RS_BUSY), 32'h1);
      chk("t2.stall", 32'(STALL), 32'h1);
      step("t2.retire", 0, 0, 1, 5, 0, 5, 0);
      chk("t2.rs_clear", 32'(RS_BUSY), 32'h0);

      // saturate register 8
      step("t3.i1", 1, 8, 0, 0, 0, 8, 8);
      step("t3.i2", 1, 8, 0, 0, 0, 8, 8);
      step("t3.i3", 1, 8, 0, 0, 0, 8, 8);
      ISSUE_VALID = 1; ISSUE_ADDR = 8; RETIRE_VALID = 0; #1;
      chk("t3.full_ready", 32'(ISSUE_READY), 32'h0);
      step("t3.i4_blocked", 1, 8, 0, 0, 0, 8, 8);
      step("t3.retire_issue", 1, 8, 1, 8, 0, 8, 8);
      ISSUE_VALID = 1; ISSUE_ADDR = 8; RETIRE_VALID = 0; #1;
      chk("t3.still_full", 32'(ISSUE_READY), 32'h0);

      // register 0 is never tracked
      step("t4.issue0", 1, 0, 0, 0, 0, 0, 0);
      chk("t4.rt_busy0", 32'(RT_BUSY), 32'h0);
      chk("t4.vec_bit0", 32'(BUSY_VEC[0]), 32'h0);
      step("t4.retire0", 0, 0, 1, 0, 0, 0, 0);
      chk("t4.err0", 32'(ERR_UNDERFLOW), 32'h0);

      // mid-run reset with register 8 still busy
      do_reset("t1.midreset");

      // underflow is sticky through flush, cleared by reset
      step("t5.retire12", 0, 0, 1, 12, 0, 12, 0);
      chk("t5.err_set", 32'(ERR_UNDERFLOW), 32'h1);
      step("t5.flush", 0, 0, 0, 0, 1, 12, 0);
      chk("t5.err_held", 32'(ERR_UNDERFLOW), 32'h1);

      // flush wipes counters and ignores the same-cycle issue
      step("t6.i3", 1, 3, 0, 0, 0, 3, 4);
      step("t6.i4", 1, 4, 0, 0, 0, 3, 4);
      step("t6.i31", 1, 31, 0, 0, 0, 31, 4);
      chk("t6.vec_before", BUSY_VEC, 32'h8000_0018);
      step("t6.flush", 1, 3, 0, 0, 1, 3, 31);
      chk("t6.vec_after", BUSY_VEC, 32'h0);

      do_reset("t5.reset_clears_err");

      // randomized traffic concentrated on a few registers to reach saturation
      for (int n = 0; n < 600; n++) begin
         logic [4:0] ia, ra, rs, rt;
         ia = 5'($urandom_range(0, 6));
         ra = ($urandom_range(0, 3) == 0) ? ia : 5'($urandom_range(0, 6));
         rs = 5'($urandom_range(0, 7));
         rt = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
         step("rnd", 1'($urandom_range(0, 99) < 65), ia,
              1'($urandom_range(0, 99) < 45), ra,
              1'($urandom_range(0, 99) < 3), rs, rt);
         if (n == 300) do_reset("rnd.reset");
      end
      idle("final", 1, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
